// File: rtl/pong_match_controller.sv
// ---------------------------------------------------------------------------
// pong_match_controller
//
// Match-level sequencer for two-player LED Pong. It sits above the
// light-pattern FSM and decides who serves, launches the ball, produces the
// ball-step and flash timer ticks, raises rally speed by level, keeps score
// and declares a winner.
//
// Ports
//   i_Clk         system clock
//   i_r           synchronous active-high reset
//   i_serve_a     player A serve press (1-cycle pulse)
//   i_serve_b     player B serve press (1-cycle pulse)
//   i_ball_hit    pulse: ball returned by a paddle
//   i_ball_miss   pulse: rally ended
//   i_miss_side   valid with i_ball_miss; 0 = A missed, 1 = B missed
//   o_ball_start  1-cycle launch pulse to the pattern FSM
//   o_step_tick   1-cycle ball-advance tick, only during a rally
//   o_flash_tick  1-cycle flash tick, only during point display
//   o_server      0 = A serves, 1 = B serves
//   o_level       current speed level
//   o_score_a     player A score
//   o_score_b     player B score
//   o_game_over   high while the match is over
//   o_winner      valid while o_game_over; 0 = A, 1 = B
// ---------------------------------------------------------------------------
module pong_match_controller #(
    parameter int unsigned TICK_BASE      = 5_000_000,
    parameter int unsigned TICK_STEP      = 500_000,
    parameter int unsigned TICK_MIN       = 1_000_000,
    parameter int unsigned FLASH_CYCLES   = 2_500_000,
    parameter int unsigned FLASH_COUNT    = 6,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL      = 8,
    parameter int unsigned WIN_SCORE      = 7
) (
    input  logic       i_Clk,
    input  logic       i_r,
    input  logic       i_serve_a,
    input  logic       i_serve_b,
    input  logic       i_ball_hit,
    input  logic       i_ball_miss,
    input  logic       i_miss_side,
    output logic       o_ball_start,
    output logic       o_step_tick,
    output logic       o_flash_tick,
    output logic       o_server,
    output logic [3:0] o_level,
    output logic [3:0] o_score_a,
    output logic [3:0] o_score_b,
    output logic       o_game_over,
    output logic       o_winner
);

    typedef enum logic [2:0] {
        S_SERVE,
        S_LAUNCH,
        S_RALLY,
        S_POINT,
        S_GAME_OVER
    } state_t;

    localparam logic [31:0] C_TICK_BASE    = 32'(TICK_BASE);
    localparam logic [31:0] C_TICK_STEP    = 32'(TICK_STEP);
    localparam logic [31:0] C_TICK_MIN     = 32'(TICK_MIN);
    localparam logic [31:0] C_FLASH_CYCLES = 32'(FLASH_CYCLES);
    localparam logic [7:0]  C_FLASH_COUNT  = 8'(FLASH_COUNT);
    localparam logic [7:0]  C_HITS         = 8'(HITS_PER_LEVEL);
    localparam logic [3:0]  C_MAX_LEVEL    = 4'(MAX_LEVEL);
    localparam logic [3:0]  C_WIN_SCORE    = 4'(WIN_SCORE);

    state_t      r_state,      w_stateNext;
    logic [31:0] r_stepCnt,    w_stepCntNext;
    logic [31:0] r_flashCnt,   w_flashCntNext;
    logic [7:0]  r_flashNum,   w_flashNumNext;
    logic [7:0]  r_hitCnt,     w_hitCntNext;
    logic        r_missSide,   w_missSideNext;
    logic        r_ballStart,  w_ballStartNext;
    logic        r_stepTick,   w_stepTickNext;
    logic        r_flashTick,  w_flashTickNext;
    logic        r_server,     w_serverNext;
    logic [3:0]  r_level,      w_levelNext;
    logic [3:0]  r_scoreA,     w_scoreANext;
    logic [3:0]  r_scoreB,     w_scoreBNext;
    logic        r_gameOver,   w_gameOverNext;
    logic        r_winner,     w_winnerNext;

    logic [31:0] w_levelProd;
    logic [31:0] w_period;
    logic        w_serverPress;

    // Step period for the current level. The floor test is done on the
    // product before subtracting so the period never wraps below zero.
    always_comb begin
        w_levelProd = 32'(r_level) * C_TICK_STEP;
        if (w_levelProd >= C_TICK_BASE - C_TICK_MIN) begin
            w_period = C_TICK_MIN;
        end else begin
            w_period = C_TICK_BASE - w_levelProd;
        end
    end

    // Only the press of the player holding serve counts; a simultaneous
    // press by the other player is simply not looked at.
    assign w_serverPress = r_server ? i_serve_b : i_serve_a;

    // Next-state and next-register logic. Every register holds by default
    // and every pulse defaults low, so each state only lists what changes.
    always_comb begin
        w_stateNext     = r_state;
        w_stepCntNext   = r_stepCnt;
        w_flashCntNext  = r_flashCnt;
        w_flashNumNext  = r_flashNum;
        w_hitCntNext    = r_hitCnt;
        w_missSideNext  = r_missSide;
        w_ballStartNext = 1'b0;
        w_stepTickNext  = 1'b0;
        w_flashTickNext = 1'b0;
        w_serverNext    = r_server;
        w_levelNext     = r_level;
        w_scoreANext    = r_scoreA;
        w_scoreBNext    = r_scoreB;
        w_gameOverNext  = r_gameOver;
        w_winnerNext    = r_winner;

        case (r_state)
            S_SERVE: begin
                // The step counter is loaded on the same edge that raises
                // ball_start, which places the first step tick exactly one
                // period after the launch pulse.
                if (w_serverPress) begin
                    w_stateNext     = S_LAUNCH;
                    w_ballStartNext = 1'b1;
                    w_stepCntNext   = w_period - 32'd1;
                    w_hitCntNext    = '0;
                end
            end

            S_LAUNCH: begin
                w_stateNext = S_RALLY;
                if (r_stepCnt != '0) begin
                    w_stepCntNext = r_stepCnt - 32'd1;
                end
            end

            S_RALLY: begin
                // A miss ends the rally and overrides any hit in the same
                // cycle; no step tick is issued on the way out.
                if (i_ball_miss) begin
                    w_missSideNext = i_miss_side;
                    if (i_miss_side) begin
                        if (r_scoreA != 4'hF) begin
                            w_scoreANext = r_scoreA + 4'd1;
                        end
                    end else begin
                        if (r_scoreB != 4'hF) begin
                            w_scoreBNext = r_scoreB + 4'd1;
                        end
                    end
                    w_flashCntNext = C_FLASH_CYCLES - 32'd1;
                    w_flashNumNext = '0;
                    w_stateNext    = S_POINT;
                end else begin
                    // Reload uses the level in effect now, so a level
                    // change shows up only at the following reload.
                    if (r_stepCnt == '0) begin
                        w_stepTickNext = 1'b1;
                        w_stepCntNext  = w_period - 32'd1;
                    end else begin
                        w_stepCntNext = r_stepCnt - 32'd1;
                    end
                    if (i_ball_hit) begin
                        if (r_hitCnt + 8'd1 >= C_HITS) begin
                            w_hitCntNext = '0;
                            if (r_level < C_MAX_LEVEL) begin
                                w_levelNext = r_level + 4'd1;
                            end
                        end else begin
                            w_hitCntNext = r_hitCnt + 8'd1;
                        end
                    end
                end
            end

            S_POINT: begin
                // The decision is taken one cycle after the last flash tick
                // so that every flash tick is seen while still in POINT.
                if (r_flashNum >= C_FLASH_COUNT) begin
                    if (r_scoreA == C_WIN_SCORE || r_scoreB == C_WIN_SCORE) begin
                        w_stateNext    = S_GAME_OVER;
                        w_gameOverNext = 1'b1;
                        w_winnerNext   = (r_scoreB == C_WIN_SCORE);
                    end else begin
                        w_serverNext = r_missSide;
                        w_levelNext  = '0;
                        w_stateNext  = S_SERVE;
                    end
                end else if (r_flashCnt == '0) begin
                    w_flashTickNext = 1'b1;
                    w_flashCntNext  = C_FLASH_CYCLES - 32'd1;
                    w_flashNumNext  = r_flashNum + 8'd1;
                end else begin
                    w_flashCntNext = r_flashCnt - 32'd1;
                end
            end

            S_GAME_OVER: begin
                if (i_serve_a || i_serve_b) begin
                    w_scoreANext   = '0;
                    w_scoreBNext   = '0;
                    w_levelNext    = '0;
                    w_hitCntNext   = '0;
                    w_winnerNext   = 1'b0;
                    w_serverNext   = 1'b0;
                    w_gameOverNext = 1'b0;
                    w_stateNext    = S_SERVE;
                end
            end

            default: begin
                w_stateNext = S_SERVE;
            end
        endcase
    end

    // State and register bank; reset may arrive in any state, mid-rally
    // included, and returns everything to a fresh match.
    always_ff @(posedge i_Clk) begin
        if (i_r) begin
            r_state     <= S_SERVE;
            r_stepCnt   <= '0;
            r_flashCnt  <= '0;
            r_flashNum  <= '0;
            r_hitCnt    <= '0;
            r_missSide  <= 1'b0;
            r_ballStart <= 1'b0;
            r_stepTick  <= 1'b0;
            r_flashTick <= 1'b0;
            r_server    <= 1'b0;
            r_level     <= '0;
            r_scoreA    <= '0;
            r_scoreB    <= '0;
            r_gameOver  <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_stepCnt   <= w_stepCntNext;
            r_flashCnt  <= w_flashCntNext;
            r_flashNum  <= w_flashNumNext;
            r_hitCnt    <= w_hitCntNext;
            r_missSide  <= w_missSideNext;
            r_ballStart <= w_ballStartNext;
            r_stepTick  <= w_stepTickNext;
            r_flashTick <= w_flashTickNext;
            r_server    <= w_serverNext;
            r_level     <= w_levelNext;
            r_scoreA    <= w_scoreANext;
            r_scoreB    <= w_scoreBNext;
            r_gameOver  <= w_gameOverNext;
            r_winner    <= w_winnerNext;
        end
    end

    assign o_ball_start = r_ballStart;
    assign o_step_tick  = r_stepTick;
    assign o_flash_tick = r_flashTick;
    assign o_server     = r_server;
    assign o_level      = r_level;
    assign o_score_a    = r_scoreA;
    assign o_score_b    = r_scoreB;
    assign o_game_over  = r_gameOver;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_pong_match_controller.sv
// ---------------------------------------------------------------------------
// tb_pong_match_controller
//
// Directed bench for pong_match_controller using small timing parameters
// (TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, FLASH_CYCLES=3, FLASH_COUNT=2,
// HITS_PER_LEVEL=2, WIN_SCORE=2) so whole matches fit in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_pong_match_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       serveA = 1'b0;
    logic       serveB = 1'b0;
    logic       ballHit = 1'b0;
    logic       ballMiss = 1'b0;
    logic       missSide = 1'b0;
    logic       ballStart;
    logic       stepTick;
    logic       flashTick;
    logic       server;
    logic [3:0] level;
    logic [3:0] scoreA;
    logic [3:0] scoreB;
    logic       gameOver;
    logic       winner;

    int assertCount = 0;
    int failCount   = 0;
    int strayStep   = 0;
    int gap;
    int dummy;

    pong_match_controller #(
        .TICK_BASE      (10),
        .TICK_STEP      (2),
        .TICK_MIN       (4),
        .FLASH_CYCLES   (3),
        .FLASH_COUNT    (2),
        .HITS_PER_LEVEL (2),
        .MAX_LEVEL      (8),
        .WIN_SCORE      (2)
    ) dut (
        .i_Clk        (clock),
        .i_r          (reset),
        .i_serve_a    (serveA),
        .i_serve_b    (serveB),
        .i_ball_hit   (ballHit),
        .i_ball_miss  (ballMiss),
        .i_miss_side  (missSide),
        .o_ball_start (ballStart),
        .o_step_tick  (stepTick),
        .o_flash_tick (flashTick),
        .o_server     (server),
        .o_level      (level),
        .o_score_a    (scoreA),
        .o_score_b    (scoreB),
        .o_game_over  (gameOver),
        .o_winner     (winner)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Holds the given inputs across exactly one rising edge, then returns
    // 1 time unit after that edge with the inputs cleared.
    task automatic applyStimulus(input logic sa, input logic sb, input logic hit,
                                 input logic miss, input logic side);
        serveA   = sa;
        serveB   = sb;
        ballHit  = hit;
        ballMiss = miss;
        missSide = side;
        @(posedge clock);
        #1;
        serveA   = 1'b0;
        serveB   = 1'b0;
        ballHit  = 1'b0;
        ballMiss = 1'b0;
        missSide = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Idles until the next step tick; returns the number of edges taken.
    task automatic waitStep(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 60; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (stepTick) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) checkOutput("stepTimeout", 32'd0, 32'd1);
    endtask

    // Idles until the next flash tick; also counts step ticks seen meanwhile.
    task automatic waitFlash(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 60; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (stepTick) strayStep++;
            if (flashTick) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) checkOutput("flashTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset values
        applyReset();
        checkOutput("rstBallStart", 32'(ballStart), 32'd0);
        checkOutput("rstStepTick",  32'(stepTick),  32'd0);
        checkOutput("rstFlashTick", 32'(flashTick), 32'd0);
        checkOutput("rstServer",    32'(server),    32'd0);
        checkOutput("rstLevel",     32'(level),     32'd0);
        checkOutput("rstScoreA",    32'(scoreA),    32'd0);
        checkOutput("rstScoreB",    32'(scoreB),    32'd0);
        checkOutput("rstGameOver",  32'(gameOver),  32'd0);
        checkOutput("rstWinner",    32'(winner),    32'd0);

        // Serve by the non-server is ignored; A's serve launches
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrongServe", 32'(ballStart), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("serveA", 32'(ballStart), 32'd1);
        waitStep(gap);
        checkOutput("firstStep", gap, 32'd10);
        waitStep(gap);
        checkOutput("stepPeriod0", gap, 32'd10);

        // Two hits reach level 1, period 8 after the next reload
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("level0AfterOneHit", 32'(level), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("level1", 32'(level), 32'd1);
        waitStep(dummy);
        waitStep(gap);
        checkOutput("stepPeriod1", gap, 32'd8);

        // Six more hits reach level 4; period floors at 4
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("level4", 32'(level), 32'd4);
        waitStep(dummy);
        waitStep(gap);
        checkOutput("stepPeriodFloor", gap, 32'd4);

        // A misses: B scores, two flashes 3 apart, then A serves at level 0
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pt1ScoreB", 32'(scoreB), 32'd1);
        checkOutput("pt1ScoreA", 32'(scoreA), 32'd0);
        waitFlash(gap);
        checkOutput("flash1", gap, 32'd3);
        waitFlash(gap);
        checkOutput("flash2", gap, 32'd3);
        checkOutput("noStepInPoint", strayStep, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pt1Server", 32'(server), 32'd0);
        checkOutput("pt1Level",  32'(level),  32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pt1WrongServe", 32'(ballStart), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pt1Serve", 32'(ballStart), 32'd1);

        // Hit and miss together: point only, pending hit discarded
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("hitMissScoreA", 32'(scoreA), 32'd1);
        checkOutput("hitMissScoreB", 32'(scoreB), 32'd1);
        checkOutput("hitMissLevel",  32'(level),  32'd0);
        waitFlash(dummy);
        waitFlash(dummy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pt2Server", 32'(server), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pt2ServeAIgnored", 32'(ballStart), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bothServe", 32'(ballStart), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ballStartOneCycle", 32'(ballStart), 32'd0);

        // B reaches the winning score
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pt3ScoreB", 32'(scoreB), 32'd2);
        waitFlash(dummy);
        waitFlash(dummy);
        checkOutput("notOverDuringFlash", 32'(gameOver), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("gameOver", 32'(gameOver), 32'd1);
        checkOutput("winnerB",  32'(winner),   32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("missIgnoredGO", 32'(scoreB), 32'd2);
        checkOutput("scoreAHeldGO",  32'(scoreA), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("newGameOver",   32'(gameOver), 32'd0);
        checkOutput("newGameScoreA", 32'(scoreA),   32'd0);
        checkOutput("newGameScoreB", 32'(scoreB),   32'd0);
        checkOutput("newGameServer", 32'(server),   32'd0);
        checkOutput("newGameWinner", 32'(winner),   32'd0);

        // Reset in the middle of a rally
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        waitFlash(dummy);
        waitFlash(dummy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("preRstServer", 32'(server), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("preRstLevel",  32'(level),  32'd1);
        checkOutput("preRstScoreA", 32'(scoreA), 32'd1);
        applyReset();
        checkOutput("midRstLevel",    32'(level),     32'd0);
        checkOutput("midRstScoreA",   32'(scoreA),    32'd0);
        checkOutput("midRstServer",   32'(server),    32'd0);
        checkOutput("midRstStepTick", 32'(stepTick),  32'd0);
        checkOutput("midRstStart",    32'(ballStart), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midRstServeB", 32'(ballStart), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midRstServeA", 32'(ballStart), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
